// File: rtl/tap_cmd_if.sv
// Command handshake between the test-mode register bank and the TAP master.
interface tap_cmd_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_key;
    logic [4:0] cmd_length;
    logic [2:0] cmd_mode;

    modport master (
        output cmd_valid, cmd_op, cmd_key, cmd_length, cmd_mode,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_key, cmd_length, cmd_mode,
        output cmd_ready
    );
endinterface

// File: rtl/tap_sequencer.sv
// TAP master: expands one-word commands into tdi/tck/trstb bit-serial
// sequences and captures tdo on tck falling edges while tde is high.
module tap_sequencer #(
    parameter int         HALF_CYC  = 4,
    parameter int         SETUP_CYC = 1,
    parameter logic [7:0] KEY       = 8'h96
) (
    input  logic       clk,
    input  logic       rst,
    tap_cmd_if.slave   cmd,
    output logic       busy,
    output logic       done,
    input  logic       tdo,
    input  logic       tde,
    output logic [7:0] rx_data,
    output logic       tdi,
    output logic       tck,
    output logic       trstb
);

    if (SETUP_CYC < 1 || SETUP_CYC > HALF_CYC - 1) begin : g_param_check
        $error("tap_sequencer: SETUP_CYC must be in 1..HALF_CYC-1");
    end

    localparam int PW = $clog2(2 * HALF_CYC);
    localparam logic [PW-1:0] P_LAST = PW'(2 * HALF_CYC - 1);
    localparam logic [PW-1:0] P_RISE = PW'(SETUP_CYC);
    localparam logic [PW-1:0] P_FALL = PW'(SETUP_CYC + HALF_CYC);
    localparam logic [PW-1:0] P_SAMP = PW'(SETUP_CYC + HALF_CYC - 1);

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_ATPG  = 2'd2;
    localparam logic [1:0] OP_SEND  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        SHIFT,
        TRAIL,
        DONE
    } state_t;

    state_t        state;
    logic          ready;
    logic [1:0]    op;
    logic [15:0]   sr;
    logic [3:0]    bit_cnt;
    logic [3:0]    last_bit;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nxt;
    logic          bit_end;
    logic          tck_nxt;
    logic          sample;

    assign cmd.cmd_ready = ready;

    always_comb begin
        bit_end   = (phase == P_LAST);
        phase_nxt = bit_end ? '0 : phase + 1'b1;
        tck_nxt   = (phase_nxt >= P_RISE) && (phase_nxt < P_FALL);
        // Last high cycle: tck drops on this edge, so tdo is captured now.
        sample    = (phase == P_SAMP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            tdi      <= 1'b0;
            tck      <= 1'b0;
            trstb    <= 1'b0;
            op       <= '0;
            sr       <= '0;
            bit_cnt  <= '0;
            last_bit <= '0;
            phase    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    tdi  <= 1'b0;
                    tck  <= 1'b0;
                    done <= 1'b0;
                    if (cmd.cmd_valid && ready) begin
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        op      <= cmd.cmd_op;
                        phase   <= '0;
                        bit_cnt <= '0;
                        if (cmd.cmd_op == OP_SEND) begin
                            state    <= SHIFT;
                            sr       <= {cmd.cmd_key, 8'h00};
                            last_bit <= 4'd7;
                            tdi      <= cmd.cmd_key[7];
                        end else begin
                            state <= RST;
                            trstb <= 1'b0;
                            if (cmd.cmd_op == OP_ATPG) begin
                                sr       <= {KEY, cmd.cmd_length, cmd.cmd_mode};
                                last_bit <= 4'd15;
                            end else begin
                                sr       <= {cmd.cmd_key, 8'h00};
                                last_bit <= 4'd7;
                            end
                        end
                    end else begin
                        ready <= 1'b1;
                    end
                end
                RST, SHIFT, TRAIL: begin
                    phase <= phase_nxt;
                    tck   <= tck_nxt;
                    if (sample && tde) begin
                        rx_data <= {rx_data[6:0], tdo};
                    end
                    if (bit_end) begin
                        if (state == RST) begin
                            if (bit_cnt == 4'd3) begin
                                bit_cnt <= '0;
                                trstb   <= 1'b1;
                                if (op == OP_RESET) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state <= SHIFT;
                                    tdi   <= sr[15];
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else if (state == SHIFT) begin
                            if (bit_cnt == last_bit) begin
                                bit_cnt <= '0;
                                tdi     <= 1'b0;
                                if (op == OP_SEND) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state <= TRAIL;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                sr      <= {sr[14:0], 1'b0};
                                tdi     <= sr[14];
                            end
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    tdi   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tap_sequencer.sv
// Directed bench for tap_sequencer: command expansion, timing, capture
// and reset behaviour with HALF_CYC=4, SETUP_CYC=1.
module tb_tap_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tde = 1'b0;
    logic       loop = 1'b0;
    logic       tdo;
    logic       busy;
    logic       done;
    logic       tdi;
    logic       tck;
    logic       trstb;
    logic [7:0] rx_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int viol = 0;
    int dones = 0;
    int pulses = 0;
    logic        prev_tck = 1'b0;
    logic        prev_tdi = 1'b0;
    logic [23:0] tdi_bits = '0;
    logic [23:0] trst_bits = '0;

    tap_cmd_if cif ();

    assign tdo = loop ? tdi : 1'b0;

    always #5 clk = ~clk;

    tap_sequencer #(
        .HALF_CYC (4),
        .SETUP_CYC(1),
        .KEY      (8'h96)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cmd    (cif),
        .busy   (busy),
        .done   (done),
        .tdo    (tdo),
        .tde    (tde),
        .rx_data(rx_data),
        .tdi    (tdi),
        .tck    (tck),
        .trstb  (trstb)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Pin monitor: records tdi/trstb at every tck rise and flags tdi
    // moving while tck is high (including on the rising cycle itself).
    always @(negedge clk) begin
        if (tck && !prev_tck) begin
            tdi_bits  <= {tdi_bits[22:0], tdi};
            trst_bits <= {trst_bits[22:0], trstb};
            pulses    <= pulses + 1;
        end
        if (tdi !== prev_tdi && tck === 1'b1) viol <= viol + 1;
        if (done === 1'b1) dones <= dones + 1;
        prev_tck <= tck;
        prev_tdi <= tdi;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [7:0] key,
                       input logic [4:0] len, input logic [2:0] mode,
                       input int nbits, input string tag);
        int e;
        int lat;
        int p0;
        bit bdrop;
        p0 = pulses;
        @(negedge clk);
        cif.cmd_valid  = 1'b1;
        cif.cmd_op     = op;
        cif.cmd_key    = key;
        cif.cmd_length = len;
        cif.cmd_mode   = mode;
        @(negedge clk);
        e = cyc;
        cif.cmd_valid  = 1'b0;
        cif.cmd_op     = 2'd0;
        cif.cmd_key    = ~key;
        cif.cmd_length = ~len;
        cif.cmd_mode   = ~mode;
        lat = -1;
        bdrop = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (busy !== 1'b1) bdrop = 1'b1;
            if (done === 1'b1) begin
                lat = cyc - e;
                break;
            end
            @(negedge clk);
        end
        check({tag, ".latency"}, lat, 8 * nbits);
        check({tag, ".busy"}, {31'd0, bdrop}, 32'd0);
        check({tag, ".pulses"}, pulses - p0, nbits);
        @(negedge clk);
        check({tag, ".ready_after"}, {31'd0, cif.cmd_ready}, 32'd1);
        check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, ".tdi_idle"}, {31'd0, tdi}, 32'd0);
    endtask

    initial begin
        int d0;
        int p0;
        bit rdy_seen;
        cif.cmd_valid  = 1'b0;
        cif.cmd_op     = 2'd0;
        cif.cmd_key    = 8'h00;
        cif.cmd_length = 5'd0;
        cif.cmd_mode   = 3'd0;

        repeat (3) @(negedge clk);
        check("rst.tck", {31'd0, tck}, 32'd0);
        check("rst.tdi", {31'd0, tdi}, 32'd0);
        check("rst.trstb", {31'd0, trstb}, 32'd0);
        check("rst.ready", {31'd0, cif.cmd_ready}, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.rx", {24'd0, rx_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel.ready", {31'd0, cif.cmd_ready}, 32'd1);
        check("rel.trstb", {31'd0, trstb}, 32'd0);

        run(2'd0, 8'h00, 5'd0, 3'd0, 4, "reset");
        check("reset.tdi", {28'd0, tdi_bits[3:0]}, 32'h0);
        check("reset.trst", {28'd0, trst_bits[3:0]}, 32'h0);
        check("reset.trstb_end", {31'd0, trstb}, 32'd1);

        run(2'd1, 8'h96, 5'd0, 3'd0, 13, "setkey");
        check("setkey.tdi", {19'd0, tdi_bits[12:0]}, 32'h12C);
        check("setkey.trst", {19'd0, trst_bits[12:0]}, 32'h1FF);
        check("setkey.rx_hold", {24'd0, rx_data}, 32'h00);

        loop = 1'b1;
        tde = 1'b1;
        run(2'd3, 8'hA5, 5'd0, 3'd0, 8, "send");
        loop = 1'b0;
        tde = 1'b0;
        check("send.tdi", {24'd0, tdi_bits[7:0]}, 32'hA5);
        check("send.trst", {24'd0, trst_bits[7:0]}, 32'hFF);
        check("send.rx", {24'd0, rx_data}, 32'hA5);
        check("send.trstb_end", {31'd0, trstb}, 32'd1);

        run(2'd2, 8'h00, 5'd3, 3'b101, 21, "atpg");
        check("atpg.tdi", {11'd0, tdi_bits[20:0]}, 32'h12C3A);
        check("atpg.trst", {11'd0, trst_bits[20:0]}, 32'h1FFFF);
        check("atpg.rx_hold", {24'd0, rx_data}, 32'hA5);

        check("setup.viol", viol, 0);

        d0 = dones;
        rdy_seen = 1'b0;
        @(negedge clk);
        cif.cmd_valid  = 1'b1;
        cif.cmd_op     = 2'd2;
        cif.cmd_length = 5'd3;
        cif.cmd_mode   = 3'b101;
        @(negedge clk);
        check("abort.busy", {31'd0, busy}, 32'd1);
        for (int i = 1; i < 50; i++) begin
            @(negedge clk);
            if (cif.cmd_ready !== 1'b0) rdy_seen = 1'b1;
        end
        check("abort.ignored", {31'd0, rdy_seen}, 32'd0);
        rst = 1'b1;
        cif.cmd_valid = 1'b0;
        @(negedge clk);
        check("abort.tck", {31'd0, tck}, 32'd0);
        check("abort.trstb", {31'd0, trstb}, 32'd0);
        check("abort.busy_low", {31'd0, busy}, 32'd0);
        check("abort.done", {31'd0, done}, 32'd0);
        check("abort.tdi", {31'd0, tdi}, 32'd0);
        p0 = pulses;
        rst = 1'b0;
        @(negedge clk);
        check("abort.ready", {31'd0, cif.cmd_ready}, 32'd1);
        repeat (20) @(negedge clk);
        check("abort.no_pulses", pulses - p0, 0);
        check("abort.no_done", dones - d0, 0);
        check("abort.trstb_hold", {31'd0, trstb}, 32'd0);
        check("final.viol", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
